add_sequencer: RTL and testbench

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_seq_pkg.sv | 16 +
 rtl/add_sixteen.sv | 29 ++
 rtl/add_sequencer.sv | 92 +++++++++
 tb/tb_add_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared widths and FSM state type for the word-serial 64-bit add/subtract sequencer.
package add_seq_pkg;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 4;
  localparam int DATA_W    = WORD_W * NUM_WORDS;
  localparam int PASS_W    = $clog2(NUM_WORDS);
  localparam int SHIFT_W   = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : add_seq_pkg

// File: rtl/add_sixteen.sv
// One WORD_W-bit ripple-carry adder slice with carry-out and signed overflow of its top bit.
module add_sixteen
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  always_comb begin
    logic cy;
    logic cy_msb;
    // NOTE: blocking assignments here because cy must ripple bit by bit within one evaluation.
    cy     = cin;
    cy_msb = 1'b0;
    sum    = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (i == WORD_W - 1) cy_msb = cy;
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
    ovf  = cy ^ cy_msb;
  end

endmodule : add_sixteen

// File: rtl/add_sequencer.sv
// 64-bit add/subtract built from four least-significant-first passes through one shared
// 16-bit adder; operands latched on start, flags registered on the last pass.
module add_sequencer
  import add_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              overflow
);

  state_t              state, state_nxt;
  logic [PASS_W-1:0]   k;
  logic                cy_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                sub_q;

  logic [SHIFT_W+PASS_W-1:0] base;
  logic [WORD_W-1:0]         add_a, add_b, add_sum;
  logic                      add_cout, add_ovf;
  logic                      accept;

  assign accept = (state == IDLE) && start;
  assign base   = {k, {SHIFT_W{1'b0}}};
  assign add_a  = a_q[base +: WORD_W];
  assign add_b  = b_q[base +: WORD_W] ^ {WORD_W{sub_q}};

  add_sixteen u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (cy_q),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // NOTE: operand registers carry no reset; they are always loaded before being consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      k        <= '0;
      cy_q     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        k    <= '0;
        cy_q <= sub;
      end else if (state == ADD) begin
        result[base +: WORD_W] <= add_sum;
        cy_q <= add_cout;
        k    <= k + 1'b1;
        if (k == PASS_W'(NUM_WORDS - 1)) begin
          carry    <= add_cout;
          overflow <= add_ovf;
        end
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (k == PASS_W'(NUM_WORDS - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule : add_sequencer

// File: tb/tb_add_sequencer.sv
// Scoreboard bench for add_sequencer: stimulus pushes model results, a monitor checks on done.
module tb_add_sequencer;

  typedef struct packed {
    logic [63:0] res;
    logic        cy;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        carry;
  logic        overflow;

  int   checks;
  int   errors;
  int   done_cnt;
  exp_t sb_q[$];
  exp_t last_exp;

  add_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word 65-bit arithmetic, subtraction as a + ~b + 1.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic s);
    exp_t        e;
    logic [63:0] yy;
    logic [64:0] full;
    yy    = s ? ~y : y;
    full  = {1'b0, x} + {1'b0, yy} + 65'(s);
    e.res = full[63:0];
    e.cy  = full[64];
    e.ovf = (x[63] == yy[63]) && (e.res[63] != x[63]);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("carry", 64'(carry), 64'(e.cy));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  function automatic logic [63:0] rand_word64();
    logic [63:0] v;
    for (int w = 0; w < 4; w++) begin
      case ($urandom_range(0, 3))
        0:       v[w*16 +: 16] = 16'h0000;
        1:       v[w*16 +: 16] = 16'hFFFF;
        default: v[w*16 +: 16] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  // Call just after a rising edge (or at a falling edge) with the DUT idle.
  task automatic issue(input logic [63:0] ta, input logic [63:0] tb_v, input logic ts);
    int lat;
    last_exp = model(ta, tb_v, ts);
    sb_q.push_back(last_exp);
    start = 1'b1; a = ta; b = tb_v; sub = ts;
    @(posedge clk); #1;
    start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_edges", 64'(lat), 64'(5));
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    checks = 0; errors = 0; done_cnt = 0;
    reset_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", result, 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));

    // Release on a falling edge; the very next rising edge must accept start.
    @(negedge clk);
    reset_n = 1'b1;
    issue(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    issue(64'd5, 64'd7, 1'b1);
    issue(64'd7, 64'd5, 1'b1);
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1);

    // Outputs hold in IDLE after completion.
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", result, last_exp.res);
    check("hold_carry", 64'(carry), 64'(last_exp.cy));
    check("hold_busy", 64'(busy), 64'(0));

    // Starts raised during ADD and during DONE must be ignored.
    d0 = done_cnt;
    last_exp = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    sb_q.push_back(last_exp);
    start = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("busy_in_add", 64'(busy), 64'(1));
    start = 1'b1; a = 64'hDEAD_BEEF_DEAD_BEEF; b = 64'h1111_2222_3333_4444; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    check("done_seen", 64'(done), 64'(1));
    start = 1'b1; a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_busy", 64'(busy), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    check("ignored_result", result, last_exp.res);
    check("ignored_done_count", 64'(done_cnt - d0), 64'(1));

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      issue(rand_word64(), rand_word64(), 1'($urandom));
    end

    // Reset during pass k=2 discards the operation.
    d0 = done_cnt;
    start = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_result", result, 64'(0));
    check("midrst_carry", 64'(carry), 64'(0));
    check("midrst_overflow", 64'(overflow), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_rst", 64'(done_cnt - d0), 64'(0));
    check("idle_after_rst", 64'(busy), 64'(0));

    issue(64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0001, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_add_sequencer
